pong_game_ctrl: RTL and testbench

- Per-frame game sequencer for the pong/DX-ball display path.
- Owns ball and paddle position registers (ballx, bally, padup, padwn) that feed the colour-bar renderer. Coordinates are in the renderer's convention: screen x = ballx+50, screen line = 430-bally.
- Runs ball physics, wall and paddle collisions, scoring, and the serve/point/game-over state machine.
- Updates exactly once per frame, during vertical blank, so positions never change mid-scan.

---
 rtl/pong_game_ctrl_if.sv | 35 +++
 rtl/pong_game_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_pong_game_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/pong_game_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pong_game_ctrl_if
// Brief    : Sync-counter, button and position/score bundle of the game core.
// Revision : 1.0
// ============================================================================
interface pong_game_ctrl_if;
  logic [10:0] pixel_count0;
  logic [9:0]  line_count0;
  logic        btn_up_l;
  logic        btn_up_r;
  logic        btn_dn_l;
  logic        btn_dn_r;
  logic        btn_serve;
  logic [9:0]  ballx;
  logic [8:0]  bally;
  logic [9:0]  padup;
  logic [9:0]  padwn;
  logic [3:0]  score_up;
  logic [3:0]  score_dn;
  logic [1:0]  game_state;

  modport master (
    output pixel_count0, line_count0,
    output btn_up_l, btn_up_r, btn_dn_l, btn_dn_r, btn_serve,
    input  ballx, bally, padup, padwn, score_up, score_dn, game_state
  );

  modport slave (
    input  pixel_count0, line_count0,
    input  btn_up_l, btn_up_r, btn_dn_l, btn_dn_r, btn_serve,
    output ballx, bally, padup, padwn, score_up, score_dn, game_state
  );
endinterface
`default_nettype wire

// File: rtl/pong_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pong_game_ctrl
// Brief    : Once-per-frame pong sequencer: ball physics, paddles, scoring.
// Revision : 1.0
// ============================================================================
module pong_game_ctrl #(
  parameter int FIELD_W      = 256,
  parameter int BALL_R       = 10,
  parameter int PAD_LEN      = 48,
  parameter int PAD_Y        = 10,
  parameter int FIELD_H      = 400,
  parameter int PAD_STEP     = 4,
  parameter int BALL_DX      = 2,
  parameter int BALL_DY      = 2,
  parameter int PAUSE_FRAMES = 60,
  parameter int WIN_SCORE    = 7
) (
  input  logic            pixel_clock,
  input  logic            reset,
  pong_game_ctrl_if.slave bus
);
  localparam logic [1:0] c_st_serve = 2'b00;
  localparam logic [1:0] c_st_play  = 2'b01;
  localparam logic [1:0] c_st_point = 2'b10;
  localparam logic [1:0] c_st_over  = 2'b11;

  localparam logic signed [10:0] c_pad_step = 11'(PAD_STEP);
  localparam logic signed [10:0] c_pad_max  = 11'(FIELD_W - PAD_LEN);
  localparam logic signed [10:0] c_pad_len  = 11'(PAD_LEN);
  localparam logic signed [10:0] c_pad_home = 11'((FIELD_W - PAD_LEN) / 2);
  localparam logic signed [10:0] c_dx       = 11'(BALL_DX);
  localparam logic signed [10:0] c_dy       = 11'(BALL_DY);
  localparam logic signed [10:0] c_x_min    = 11'(BALL_R);
  localparam logic signed [10:0] c_x_max    = 11'(FIELD_W - BALL_R);
  localparam logic signed [10:0] c_y_min    = 11'(PAD_Y + BALL_R);
  localparam logic signed [10:0] c_y_max    = 11'(FIELD_H - PAD_Y - BALL_R);
  localparam logic signed [10:0] c_x_home   = 11'(FIELD_W / 2);
  localparam logic signed [10:0] c_y_home   = 11'(FIELD_H / 2);
  localparam logic [6:0]         c_pause_last = 7'(PAUSE_FRAMES - 1);
  localparam logic [3:0]         c_win      = 4'(WIN_SCORE);

  logic [9:0] ballx_q, ballx_d, padup_q, padup_d, padwn_q, padwn_d;
  logic [8:0] bally_q, bally_d;
  logic [3:0] score_up_q, score_up_d, score_dn_q, score_dn_d;
  logic [1:0] state_q, state_d;
  logic [6:0] pause_q, pause_d;
  logic       dir_right_q, dir_right_d, dir_up_q, dir_up_d;
  logic       loser_bot_q, loser_bot_d;

  logic              w_tick, w_hit_dn, w_hit_up, w_pads_live;
  logic signed [10:0] w_bx, w_by, w_nx, w_ny, w_xn;

  // Signed 11-bit step then clamp, so a paddle at an edge can never wrap.
  function automatic logic [9:0] pad_next(input logic [9:0] pad, input logic l, input logic r);
    logic signed [10:0] p;
    p = $signed({1'b0, pad});
    if (l && !r)      p = p - c_pad_step;
    else if (r && !l) p = p + c_pad_step;
    if (p < 11'sd0)         p = 11'sd0;
    else if (p > c_pad_max) p = c_pad_max;
    return p[9:0];
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s >= c_win) ? c_win : s + 4'd1;
  endfunction

  assign w_tick = (bus.line_count0 == 10'd480) && (bus.pixel_count0 == 11'd0);
  assign w_bx   = $signed({1'b0, ballx_q});
  assign w_by   = $signed({2'b00, bally_q});
  assign w_nx   = dir_right_q ? w_bx + c_dx : w_bx - c_dx;
  assign w_ny   = dir_up_q    ? w_by + c_dy : w_by - c_dy;
  assign w_xn   = (w_nx <= c_x_min) ? c_x_min : (w_nx >= c_x_max) ? c_x_max : w_nx;

  // Paddle hit windows use the post-x-step ball position, both edges inclusive.
  assign w_hit_dn = (w_xn >= $signed({1'b0, padwn_q})) &&
                    (w_xn <= $signed({1'b0, padwn_q}) + c_pad_len);
  assign w_hit_up = (w_xn >= $signed({1'b0, padup_q})) &&
                    (w_xn <= $signed({1'b0, padup_q}) + c_pad_len);
  assign w_pads_live = (state_q == c_st_serve) || (state_q == c_st_play);

  always_comb begin
    ballx_d     = ballx_q;
    bally_d     = bally_q;
    padup_d     = padup_q;
    padwn_d     = padwn_q;
    score_up_d  = score_up_q;
    score_dn_d  = score_dn_q;
    state_d     = state_q;
    pause_d     = pause_q;
    dir_right_d = dir_right_q;
    dir_up_d    = dir_up_q;
    loser_bot_d = loser_bot_q;
    if (w_tick) begin
      case (state_q)
        c_st_serve: begin
          if (bus.btn_serve) begin
            state_d     = c_st_play;
            dir_right_d = 1'b1;
            dir_up_d    = !loser_bot_q;
          end
        end
        c_st_play: begin
          ballx_d = w_xn[9:0];
          if (w_nx <= c_x_min)      dir_right_d = 1'b1;
          else if (w_nx >= c_x_max) dir_right_d = 1'b0;
          if (!dir_up_q && (w_ny <= c_y_min)) begin
            bally_d = c_y_min[8:0];
            if (w_hit_dn) begin
              dir_up_d = 1'b1;
            end else begin
              score_up_d  = sat_inc(score_up_q);
              loser_bot_d = 1'b1;
              state_d     = c_st_point;
            end
          end else if (dir_up_q && (w_ny >= c_y_max)) begin
            bally_d = c_y_max[8:0];
            if (w_hit_up) begin
              dir_up_d = 1'b0;
            end else begin
              score_dn_d  = sat_inc(score_dn_q);
              loser_bot_d = 1'b0;
              state_d     = c_st_point;
            end
          end else begin
            bally_d = w_ny[8:0];
          end
        end
        c_st_point: begin
          if (pause_q == c_pause_last) begin
            pause_d = 7'd0;
            ballx_d = c_x_home[9:0];
            bally_d = c_y_home[8:0];
            state_d = ((score_up_q == c_win) || (score_dn_q == c_win)) ? c_st_over : c_st_serve;
          end else begin
            pause_d = pause_q + 7'd1;
          end
        end
        default: begin
          if (bus.btn_serve) begin
            score_up_d = 4'd0;
            score_dn_d = 4'd0;
            ballx_d    = c_x_home[9:0];
            bally_d    = c_y_home[8:0];
            padup_d    = c_pad_home[9:0];
            padwn_d    = c_pad_home[9:0];
            state_d    = c_st_serve;
          end
        end
      endcase
      if (w_pads_live) begin
        padup_d = pad_next(padup_q, bus.btn_up_l, bus.btn_up_r);
        padwn_d = pad_next(padwn_q, bus.btn_dn_l, bus.btn_dn_r);
      end
    end
  end

  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      ballx_q     <= c_x_home[9:0];
      bally_q     <= c_y_home[8:0];
      padup_q     <= c_pad_home[9:0];
      padwn_q     <= c_pad_home[9:0];
      score_up_q  <= 4'd0;
      score_dn_q  <= 4'd0;
      state_q     <= c_st_serve;
      pause_q     <= 7'd0;
      dir_right_q <= 1'b1;
      dir_up_q    <= 1'b0;
      loser_bot_q <= 1'b1;
    end else begin
      ballx_q     <= ballx_d;
      bally_q     <= bally_d;
      padup_q     <= padup_d;
      padwn_q     <= padwn_d;
      score_up_q  <= score_up_d;
      score_dn_q  <= score_dn_d;
      state_q     <= state_d;
      pause_q     <= pause_d;
      dir_right_q <= dir_right_d;
      dir_up_q    <= dir_up_d;
      loser_bot_q <= loser_bot_d;
    end
  end

  assign bus.ballx      = ballx_q;
  assign bus.bally      = bally_q;
  assign bus.padup      = padup_q;
  assign bus.padwn      = padwn_q;
  assign bus.score_up   = score_up_q;
  assign bus.score_dn   = score_dn_q;
  assign bus.game_state = state_q;
endmodule
`default_nettype wire

// File: tb/tb_pong_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pong_game_ctrl
// Brief    : Directed plus randomized frames against a game-rules model.
// Revision : 1.0
// ============================================================================
module tb_pong_game_ctrl;
  localparam int SERVE = 0, PLAY = 1, POINT = 2, OVER = 3;

  logic clk;
  logic rst;
  pong_game_ctrl_if bus ();

  pong_game_ctrl dut (
    .pixel_clock (clk),
    .reset       (rst),
    .bus         (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  // Game model: ball, paddles, scores, phase, direction (+1/-1), loser, pause.
  int mx, my, mpu, mpd, msu, msd, mst, mdx, mdy, mlb, mpause;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      $error("%s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".ballx"}, 32'(bus.ballx), mx);
    chk({tag, ".bally"}, 32'(bus.bally), my);
    chk({tag, ".padup"}, 32'(bus.padup), mpu);
    chk({tag, ".padwn"}, 32'(bus.padwn), mpd);
    chk({tag, ".score_up"}, 32'(bus.score_up), msu);
    chk({tag, ".score_dn"}, 32'(bus.score_dn), msd);
    chk({tag, ".state"}, 32'(bus.game_state), mst);
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  task automatic model_reset();
    mx = 128; my = 200; mpu = 104; mpd = 104;
    msu = 0; msd = 0; mst = SERVE;
    mdx = 1; mdy = -1; mlb = 1; mpause = 0;
  endtask

  task automatic model_tick(input logic ul, ur, dl, dr, sv);
    int was;
    int nx;
    int ny;
    was = mst;
    case (mst)
      SERVE: if (sv) begin mst = PLAY; mdx = 1; mdy = mlb ? -1 : 1; end
      PLAY: begin
        nx = mx + 2 * mdx;
        if (nx <= 10) begin nx = 10; mdx = 1; end
        else if (nx >= 246) begin nx = 246; mdx = -1; end
        mx = nx;
        ny = my + 2 * mdy;
        if (mdy < 0 && ny <= 20) begin
          ny = 20;
          if (mx >= mpd && mx <= mpd + 48) mdy = 1;
          else begin msu = (msu < 7) ? msu + 1 : 7; mlb = 1; mst = POINT; end
        end else if (mdy > 0 && ny >= 380) begin
          ny = 380;
          if (mx >= mpu && mx <= mpu + 48) mdy = -1;
          else begin msd = (msd < 7) ? msd + 1 : 7; mlb = 0; mst = POINT; end
        end
        my = ny;
      end
      POINT: begin
        mpause++;
        if (mpause == 60) begin
          mpause = 0; mx = 128; my = 200;
          mst = (msu == 7 || msd == 7) ? OVER : SERVE;
        end
      end
      default: if (sv) begin
        msu = 0; msd = 0; mx = 128; my = 200; mpu = 104; mpd = 104; mst = SERVE;
      end
    endcase
    if (was == SERVE || was == PLAY) begin
      mpu = clampi(mpu + 4 * (int'(ur) - int'(ul)), 0, 208);
      mpd = clampi(mpd + 4 * (int'(dr) - int'(dl)), 0, 208);
    end
  endtask

  task automatic set_btns(input logic ul, ur, dl, dr, sv);
    bus.btn_up_l = ul; bus.btn_up_r = ur;
    bus.btn_dn_l = dl; bus.btn_dn_r = dr; bus.btn_serve = sv;
  endtask

  // A few random non-tick cycles (random buttons, outputs must hold), then one tick.
  task automatic frame(input logic ul, ur, dl, dr, sv);
    int n;
    n = $urandom_range(0, 2);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      case ($urandom_range(0, 2))
        0: begin bus.line_count0 = 10'd480; bus.pixel_count0 = 11'($urandom_range(1, 799)); end
        1: begin bus.pixel_count0 = 11'd0; bus.line_count0 = 10'($urandom_range(0, 479)); end
        default: begin
          bus.pixel_count0 = 11'($urandom_range(1, 799));
          bus.line_count0  = 10'($urandom_range(0, 524));
        end
      endcase
      set_btns(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      @(posedge clk);
      #1;
      check_all("hold");
    end
    @(negedge clk);
    bus.pixel_count0 = 11'd0;
    bus.line_count0  = 10'd480;
    set_btns(ul, ur, dl, dr, sv);
    @(posedge clk);
    #1;
    model_tick(ul, ur, dl, dr, sv);
    check_all("tick");
  endtask

  task automatic reset_dut(input logic on_tick);
    @(negedge clk);
    rst = 1'b1;
    if (on_tick) begin bus.pixel_count0 = 11'd0; bus.line_count0 = 10'd480; end
    else begin bus.pixel_count0 = 11'($urandom_range(1, 799)); bus.line_count0 = 10'd100; end
    set_btns(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    @(posedge clk);
    #1;
    model_reset();
    check_all("reset");
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.pixel_count0 = 11'd0;
    bus.line_count0  = 10'd0;
    set_btns(0, 0, 0, 0, 0);
    model_reset();

    // Reset with a coincident tick, then idle frames.
    reset_dut(1'b1);
    for (int k = 0; k < 3; k++) frame(0, 0, 0, 0, 0);
    chk("idle.state", 32'(bus.game_state), 0);
    chk("idle.ballx", 32'(bus.ballx), 128);

    // Paddle stepping, clamp at 208, and both-buttons hold.
    for (int k = 0; k < 30; k++) frame(0, 0, 0, 1, 0);
    chk("clamp.padwn", 32'(bus.padwn), 208);
    for (int k = 0; k < 3; k++) frame(0, 0, 1, 1, 0);
    chk("both.padwn", 32'(bus.padwn), 208);

    // Default serve: wall bounce at tick 59, bottom miss at tick 90.
    reset_dut(1'b0);
    frame(0, 0, 0, 0, 1);
    for (int k = 1; k <= 90; k++) begin
      frame(0, 0, 0, 0, 0);
      if (k == 59) chk("t59.ballx", 32'(bus.ballx), 246);
    end
    chk("t90.ballx", 32'(bus.ballx), 184);
    chk("t90.bally", 32'(bus.bally), 20);
    chk("t90.score_up", 32'(bus.score_up), 1);
    chk("t90.state", 32'(bus.game_state), 2);
    for (int k = 0; k < 60; k++) frame(0, 0, 0, 0, 1);
    chk("pause.state", 32'(bus.game_state), 0);
    chk("pause.bally", 32'(bus.bally), 200);

    // Paddle at 160 catches the ball at tick 90.
    reset_dut(1'b1);
    for (int k = 0; k < 14; k++) frame(0, 0, 0, 1, 0);
    chk("p160.padwn", 32'(bus.padwn), 160);
    frame(0, 0, 0, 0, 1);
    for (int k = 0; k < 90; k++) frame(0, 0, 0, 0, 0);
    chk("hit.bally", 32'(bus.bally), 20);
    chk("hit.state", 32'(bus.game_state), 1);
    frame(0, 0, 0, 0, 0);
    chk("hit91.bally", 32'(bus.bally), 22);
    chk("hit91.score_up", 32'(bus.score_up), 0);

    // Reset mid-play on a non-tick cycle.
    for (int k = 0; k < 17; k++) frame(0, 0, 0, 0, 1);
    reset_dut(1'b0);
    chk("midrst.state", 32'(bus.game_state), 0);

    // Seven bottom misses run the game to GAME_OVER, then restart.
    for (int f = 0; f < 3000 && mst != OVER; f++) frame(0, 0, 0, 0, (mst == SERVE));
    chk("over.state", 32'(bus.game_state), 3);
    chk("over.score_up", 32'(bus.score_up), 7);
    for (int k = 0; k < 3; k++) frame(1, 0, 0, 1, 0);
    frame(0, 0, 0, 0, 1);
    chk("restart.state", 32'(bus.game_state), 0);
    chk("restart.score_up", 32'(bus.score_up), 0);
    frame(0, 0, 0, 0, 0);
    chk("restart.hold", 32'(bus.game_state), 0);

    // Randomized play, random buttons and occasional serve presses.
    for (int f = 0; f < 1500; f++)
      frame(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
